// File: rtl/single_driver_arbiter_if.sv
// Handshake bundle for the two-source arbiter: A/B valid-ready sources in,
// registered merged output z out.
interface single_driver_arbiter_if #(
    parameter int WIDTH = 1
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    logic             z_src;

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready, z, z_valid, z_src
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready, z, z_valid, z_src
    );
endinterface

// File: rtl/single_driver_arbiter.sv
// Round-robin merge of two valid/ready sources onto one registered output,
// with a windowed toggle counter that flags an oscillating output.
module single_driver_arbiter #(
    parameter int WIDTH      = 1,
    parameter int HOLD_MAX   = 15,
    parameter int OSC_WINDOW = 8,
    parameter int OSC_LIMIT  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    single_driver_arbiter_if.slave  bus,
    output logic                    conflict,
    output logic                    osc_flag,
    input  logic                    osc_clear
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int WW = $clog2(OSC_WINDOW);
    localparam int TW = $clog2(OSC_WINDOW + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(OSC_WINDOW - 1);
    localparam logic [TW-1:0] TOG_LIM   = TW'(OSC_LIMIT);

    state_t           state_q, state_d;
    logic             last_b_q, last_b_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             z_valid_q, z_valid_d;
    logic             z_src_q, z_src_d;
    logic             conflict_q, conflict_d;
    logic             osc_q, osc_d;
    logic [WW-1:0]    win_q, win_d;
    logic [TW-1:0]    tog_q, tog_d;
    logic             xfer_a, xfer_b;

    // Grant FSM: hold_q counts transfers already made in the current grant.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        hold_d   = hold_q;
        xfer_a   = 1'b0;
        xfer_b   = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (bus.a_valid && bus.b_valid) state_d = last_b_q ? GRANT_A : GRANT_B;
                else if (bus.a_valid)           state_d = GRANT_A;
                else if (bus.b_valid)           state_d = GRANT_B;
            end
            GRANT_A: begin
                if (!bus.a_valid) begin
                    last_b_d = 1'b0;
                    hold_d   = '0;
                    state_d  = bus.b_valid ? GRANT_B : IDLE;
                end else begin
                    xfer_a = 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (bus.b_valid) begin
                            state_d  = GRANT_B;
                            last_b_d = 1'b0;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            GRANT_B: begin
                if (!bus.b_valid) begin
                    last_b_d = 1'b1;
                    hold_d   = '0;
                    state_d  = bus.a_valid ? GRANT_A : IDLE;
                end else begin
                    xfer_b = 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (bus.a_valid) begin
                            state_d  = GRANT_A;
                            last_b_d = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Output register and oscillation monitor.
    always_comb begin
        z_d        = z_q;
        z_src_d    = z_src_q;
        z_valid_d  = xfer_a | xfer_b;
        if (xfer_a) begin
            z_d     = bus.a_data;
            z_src_d = 1'b0;
        end else if (xfer_b) begin
            z_d     = bus.b_data;
            z_src_d = 1'b1;
        end
        conflict_d = bus.a_valid & bus.b_valid & (bus.a_data != bus.b_data);

        win_d = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
        tog_d = ((win_q == WIN_LAST) ? '0 : tog_q) + TW'(z_d != z_q);
        osc_d = osc_q | (tog_d >= TOG_LIM);
        if (osc_clear) begin
            win_d = '0;
            tog_d = '0;
            osc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            hold_q     <= '0;
            z_q        <= '0;
            z_valid_q  <= 1'b0;
            z_src_q    <= 1'b0;
            conflict_q <= 1'b0;
            osc_q      <= 1'b0;
            win_q      <= '0;
            tog_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            hold_q     <= hold_d;
            z_q        <= z_d;
            z_valid_q  <= z_valid_d;
            z_src_q    <= z_src_d;
            conflict_q <= conflict_d;
            osc_q      <= osc_d;
            win_q      <= win_d;
            tog_q      <= tog_d;
        end
    end

    assign bus.a_ready = (state_q == GRANT_A);
    assign bus.b_ready = (state_q == GRANT_B);
    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;
    assign bus.z_src   = z_src_q;
    assign conflict    = conflict_q;
    assign osc_flag    = osc_q;
endmodule

// File: tb/tb_single_driver_arbiter.sv
// Directed bench: stimulus pushes expected z updates into a scoreboard queue,
// a negedge monitor pops and compares whenever z_valid is seen.
module tb_single_driver_arbiter;
    localparam int WIDTH = 1;

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic             src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic osc_clear = 1'b0;
    logic conflict, osc_flag;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    single_driver_arbiter_if #(.WIDTH(WIDTH)) bus ();

    single_driver_arbiter #(
        .WIDTH(WIDTH), .HOLD_MAX(2), .OSC_WINDOW(8), .OSC_LIMIT(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .conflict(conflict), .osc_flag(osc_flag), .osc_clear(osc_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic d, input logic s);
        exp_t e;
        e.z   = d;
        e.src = s;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            chk("ready_excl", 32'(bus.a_ready & bus.b_ready), 0);
            if (bus.z_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_z_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("z", 32'(bus.z), 32'(e.z));
                    chk("z_src", 32'(bus.z_src), 32'(e.src));
                end
            end
        end
    end

    initial begin
        logic [8:0] exp_ar;
        logic       zm, d, tg;
        int         p, w;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_data  = '0;

        // T1: reset values, then A alone for three transfers
        cyc(2);
        chk("rst_z", 32'(bus.z), 0);
        chk("rst_z_valid", 32'(bus.z_valid), 0);
        chk("rst_z_src", 32'(bus.z_src), 0);
        chk("rst_conflict", 32'(conflict), 0);
        chk("rst_osc_flag", 32'(osc_flag), 0);
        chk("rst_a_ready", 32'(bus.a_ready), 0);
        chk("rst_b_ready", 32'(bus.b_ready), 0);
        rst_n = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_data  = 1'b1;
        push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
        chk("t1_idle_a_ready", 32'(bus.a_ready), 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            chk("t1_a_ready", 32'(bus.a_ready), 1);
            chk("t1_b_ready", 32'(bus.b_ready), 0);
            if (k == 1) chk("t1_no_xfer_from_idle", 32'(bus.z_valid), 0);
        end
        bus.a_valid = 1'b0;
        cyc(1);
        chk("t1_back_idle", 32'(bus.a_ready), 0);

        // T2: both valid from reset, HOLD_MAX=2 -> A,A,B,B,A,A,B,B
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        bus.a_valid = 1'b1; bus.a_data = 1'b0;
        bus.b_valid = 1'b1; bus.b_data = 1'b1;
        exp_ar = 9'b100110011;
        push(1'b0, 1'b0); push(1'b0, 1'b0); push(1'b1, 1'b1); push(1'b1, 1'b1);
        push(1'b0, 1'b0); push(1'b0, 1'b0); push(1'b1, 1'b1); push(1'b1, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            cyc(1);
            chk("t2_a_ready", 32'(bus.a_ready), 32'(exp_ar[k]));
            chk("t2_b_ready", 32'(bus.b_ready), 32'(!exp_ar[k]));
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        cyc(1);

        // T3: one-cycle conflict; A left last so the tie goes to B
        bus.a_valid = 1'b1; bus.a_data = 1'b0;
        bus.b_valid = 1'b1; bus.b_data = 1'b1;
        cyc(1);
        chk("t3_conflict", 32'(conflict), 1);
        chk("t3_b_ready", 32'(bus.b_ready), 1);
        bus.a_valid = 1'b0;
        push(1'b1, 1'b1);
        cyc(1);
        chk("t3_conflict_gone", 32'(conflict), 0);
        bus.b_valid = 1'b0;
        cyc(1);
        chk("t3_idle", 32'(bus.b_ready), 0);

        // T4: alternate A data every cycle; flag on the 6th toggle, clear wins
        osc_clear = 1'b1;
        cyc(1);
        osc_clear = 1'b0;
        chk("t4_flag_cleared", 32'(osc_flag), 0);
        bus.a_valid = 1'b1;
        bus.a_data  = 1'b0;
        cyc(1);
        for (int i = 0; i <= 6; i++) begin
            d = (i % 2 == 1);
            bus.a_data = d;
            push(d, 1'b0);
            if (i == 6) osc_clear = 1'b1;
            cyc(1);
            if (i == 6) chk("t4_clear_beats_set", 32'(osc_flag), 0);
            else        chk("t4_osc_flag", 32'(osc_flag), (i == 5) ? 1 : 0);
        end
        osc_clear = 1'b0;

        // T5: five toggles per window, including ten in a row across a wrap
        zm = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            p  = e % 8;
            w  = e / 8;
            tg = ((w % 2 == 1) && (p >= 3)) || ((w % 2 == 0) && (w > 0) && (p <= 4));
            d  = tg ? ~zm : zm;
            zm = d;
            bus.a_data = d;
            push(d, 1'b0);
            cyc(1);
            chk("t5_osc_flag", 32'(osc_flag), 0);
        end
        bus.a_valid = 1'b0;
        cyc(1);

        // T6: reset in the middle of a B burst, then tie resolves to A
        bus.b_valid = 1'b1; bus.b_data = 1'b1;
        push(1'b1, 1'b1); push(1'b1, 1'b1);
        cyc(3);
        #5;
        rst_n = 1'b0;
        bus.a_valid = 1'b1; bus.a_data = 1'b0;
        #1;
        chk("t6_async_z", 32'(bus.z), 0);
        chk("t6_async_z_valid", 32'(bus.z_valid), 0);
        chk("t6_async_z_src", 32'(bus.z_src), 0);
        chk("t6_async_a_ready", 32'(bus.a_ready), 0);
        chk("t6_async_b_ready", 32'(bus.b_ready), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("t6_tie_a_ready", 32'(bus.a_ready), 1);
        chk("t6_tie_b_ready", 32'(bus.b_ready), 0);
        push(1'b0, 1'b0);
        cyc(1);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        cyc(2);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
